// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with a 2-bit
// saturating counter per entry. Lookup is combinational from PCF; training
// happens at the clock edge from the resolved branch in execute.
module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic [31:0] PCE,
    input  logic [31:0] PCTargetE,
    input  logic        BranchE,
    input  logic        TakenE,
    output logic        PredTakenF,
    output logic [31:0] PredPCTargetF,
    output logic        HitF
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    // Word-aligned PCs: the low two bits never take part in index or tag.
    logic [INDEX_BITS-1:0] idx_f;
    logic [INDEX_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0]   tag_f;
    logic [TAG_BITS-1:0]   tag_e;
    logic                  unused_pc_low;

    assign idx_f         = PCF[INDEX_BITS+1:2];
    assign idx_e         = PCE[INDEX_BITS+1:2];
    assign tag_f         = PCF[31:32-TAG_BITS];
    assign tag_e         = PCE[31:32-TAG_BITS];
    assign unused_pc_low = ^{PCF[1:0], PCE[1:0]};

    // Flattened views of every entry, used by the lookup mux.
    logic [ENTRIES-1:0]               valid_vec;
    logic [ENTRIES-1:0][1:0]          ctr_vec;
    logic [ENTRIES-1:0][TAG_BITS-1:0] tag_vec;
    logic [ENTRIES-1:0][31:0]         target_vec;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic                valid_q,  valid_d;
            logic [1:0]          ctr_q,    ctr_d;
            logic [TAG_BITS-1:0] tag_q,    tag_d;
            logic [31:0]         target_q, target_d;
            logic                wr_en;
            logic                hit_e;

            assign wr_en = BranchE && (idx_e == INDEX_BITS'(gi));
            assign hit_e = valid_q && (tag_q == tag_e);

            // Next-state for this entry: allocate on miss, train counter on hit.
            always_comb begin
                valid_d  = valid_q;
                ctr_d    = ctr_q;
                tag_d    = tag_q;
                target_d = target_q;
                if (wr_en) begin
                    if (!hit_e) begin
                        valid_d  = 1'b1;
                        tag_d    = tag_e;
                        target_d = PCTargetE;
                        ctr_d    = TakenE ? 2'b10 : 2'b01;
                    end else if (TakenE) begin
                        ctr_d    = (ctr_q == 2'b11) ? 2'b11 : ctr_q + 2'd1;
                        target_d = PCTargetE;
                    end else begin
                        ctr_d    = (ctr_q == 2'b00) ? 2'b00 : ctr_q - 2'd1;
                    end
                end
            end

            // Valid/counter registers; reset wins over any pending update.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    valid_q <= 1'b0;
                    ctr_q   <= 2'b01;
                end else begin
                    valid_q <= valid_d;
                    ctr_q   <= ctr_d;
                end
            end

            // Tag/target payload is never cleared; the valid bit guards it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    tag_q    <= tag_d;
                    target_q <= target_d;
                end
            end

            assign valid_vec[gi]  = valid_q;
            assign ctr_vec[gi]    = ctr_q;
            assign tag_vec[gi]    = tag_q;
            assign target_vec[gi] = target_q;
        end
    endgenerate

    // Zero-latency lookup; sees pre-update state when indices collide.
    always_comb begin
        HitF          = valid_vec[idx_f] && (tag_vec[idx_f] == tag_f);
        PredTakenF    = HitF && ctr_vec[idx_f][1];
        PredPCTargetF = HitF ? target_vec[idx_f] : 32'h0;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors with hand-computed expectations
// for the BTB lookup, training, aliasing and reset behaviour.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] PCF;
    logic [31:0] PCE;
    logic [31:0] PCTargetE;
    logic        BranchE;
    logic        TakenE;
    logic        PredTakenF;
    logic [31:0] PredPCTargetF;
    logic        HitF;

    int tests_run;
    int tests_failed;

    branch_predictor dut (
        .clk           (clk),
        .reset         (reset),
        .PCF           (PCF),
        .PCE           (PCE),
        .PCTargetE     (PCTargetE),
        .BranchE       (BranchE),
        .TakenE        (TakenE),
        .PredTakenF    (PredTakenF),
        .PredPCTargetF (PredPCTargetF),
        .HitF          (HitF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance one edge; inputs change 1ns after the edge, away from sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One training edge at pc with the given outcome, then idle.
    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        PCE       = pc;
        PCTargetE = tgt;
        TakenE    = taken;
        BranchE   = 1'b1;
        tick();
        BranchE   = 1'b0;
    endtask

    // Look up pc and compare all three outputs.
    task automatic look(input string tag, input logic [31:0] pc,
                        input logic hit, input logic pt, input logic [31:0] tgt);
        PCF = pc;
        #1;
        check({tag, ".hit"}, {31'd0, HitF}, {31'd0, hit});
        check({tag, ".pt"},  {31'd0, PredTakenF}, {31'd0, pt});
        check({tag, ".tgt"}, PredPCTargetF, tgt);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b0;
        PCF       = 32'h0;
        PCE       = 32'h0;
        PCTargetE = 32'h0;
        BranchE   = 1'b0;
        TakenE    = 1'b0;
        #2;
        tick();
        reset = 1'b1;

        look("reset", 32'h40, 1'b0, 1'b0, 32'h0);

        // Allocate taken -> counter 10.
        train(32'h40, 32'h100, 1'b1);
        look("alloc_t", 32'h40, 1'b1, 1'b1, 32'h100);

        // Three taken: 10 -> 11 -> 11 -> 11.
        for (int i = 0; i < 3; i++) begin
            train(32'h40, 32'h100, 1'b1);
            look($sformatf("inc%0d", i), 32'h40, 1'b1, 1'b1, 32'h100);
        end
        // 11 -> 10 still taken; 10 -> 01 not taken.
        train(32'h40, 32'h100, 1'b0);
        look("dec_10", 32'h40, 1'b1, 1'b1, 32'h100);
        train(32'h40, 32'h100, 1'b0);
        look("dec_01", 32'h40, 1'b1, 1'b0, 32'h100);
        // Three more not-taken: saturate at 00; target unchanged by NT update.
        for (int i = 0; i < 3; i++) begin
            train(32'h40, 32'h999, 1'b0);
            look($sformatf("sat0_%0d", i), 32'h40, 1'b1, 1'b0, 32'h100);
        end
        // 00 -> 01 still not taken, 01 -> 10 taken with new target.
        train(32'h40, 32'h100, 1'b1);
        look("up_01", 32'h40, 1'b1, 1'b0, 32'h100);
        train(32'h40, 32'h104, 1'b1);
        look("up_10", 32'h40, 1'b1, 1'b1, 32'h104);

        // BranchE=0 leaves state alone.
        PCE = 32'h40; PCTargetE = 32'h500; TakenE = 1'b0; BranchE = 1'b0;
        tick();
        look("idle", 32'h40, 1'b1, 1'b1, 32'h104);

        // Alias eviction at index 0.
        train(32'h440, 32'h200, 1'b0);
        look("alias_old", 32'h40, 1'b0, 1'b0, 32'h0);
        look("alias_new", 32'h440, 1'b1, 1'b0, 32'h200);

        // Another index coexists; low PC bits ignored.
        train(32'h47, 32'h600, 1'b1);
        look("idx1", 32'h44, 1'b1, 1'b1, 32'h600);
        look("idx0_kept", 32'h442, 1'b1, 1'b0, 32'h200);

        // Same-cycle lookup and update: pre-update state first.
        PCF = 32'h80; PCE = 32'h80; PCTargetE = 32'h300; TakenE = 1'b1; BranchE = 1'b1;
        #1;
        check("rw_same.hit", {31'd0, HitF}, 32'd0);
        tick();
        BranchE = 1'b0;
        look("rw_next", 32'h80, 1'b1, 1'b1, 32'h300);

        // Reset priority: train 0x40 to 11, then reset with an update to 0x80.
        train(32'h40, 32'h100, 1'b1);
        train(32'h40, 32'h100, 1'b1);
        look("pre_rst", 32'h40, 1'b1, 1'b1, 32'h100);
        reset = 1'b0;
        PCE = 32'h80; PCTargetE = 32'h300; TakenE = 1'b1; BranchE = 1'b1;
        tick();
        reset = 1'b1;
        BranchE = 1'b0;
        look("rst_40", 32'h40, 1'b0, 1'b0, 32'h0);
        look("rst_80", 32'h80, 1'b0, 1'b0, 32'h0);
        look("rst_44", 32'h44, 1'b0, 1'b0, 32'h0);

        // Counters reset to 01: a hit-less alloc NT then one taken gives 10.
        train(32'h48, 32'h700, 1'b0);
        look("post_nt", 32'h48, 1'b1, 1'b0, 32'h700);
        train(32'h48, 32'h704, 1'b1);
        look("post_t", 32'h48, 1'b1, 1'b1, 32'h704);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Sits directly upstream of the fetch stage. Each cycle it looks up the current PCF and supplies PredPCTargetF plus a predict-taken flag to the next-PC select logic.
- It is trained at clock edges from resolved branch outcomes in the execute stage.

Parameters:
- INDEX_BITS, 4, log2 of BTB entry count (16 entries); index = PC[INDEX_BITS+1:2].
- TAG_BITS, 26, stored tag width; must equal 30-INDEX_BITS; tag = PC[31:INDEX_BITS+2].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- PCF  input  32  fetch-stage PC used for lookup.
- PCE  input  32  PC of the instruction in execute, used for update.
- PCTargetE  input  32  resolved branch/jump target in execute.
- BranchE  input  1  update enable; execute holds a valid, unflushed control-transfer instruction. Gated by hazard logic externally.
- TakenE  input  1  resolved outcome in execute (1 = taken).
- PredTakenF  output  1  lookup hit and counter predicts taken.
- PredPCTargetF  output  32  stored target on hit, 32'h0 on miss.
- HitF  output  1  valid entry with matching tag for PCF.

Behaviour:
- Storage per entry: valid (1), tag (TAG_BITS), target (32), counter (2). Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is purely combinational from PCF and registered state, with zero latency.
  - HitF = valid[idxF] && tag[idxF]==PCF[31:INDEX_BITS+2].
  - PredTakenF = HitF && counter[idxF][1].
  - PredPCTargetF = HitF ? target[idxF] : 0.
- Update happens on a rising clk edge with reset=1 and BranchE=1, at idxE = PCE[INDEX_BITS+1:2].
  - Miss (invalid or tag mismatch): allocate and overwrite. Set valid=1, tag=PCE tag, target=PCTargetE, counter = TakenE ? 10 : 01.
  - Hit with TakenE=1: counter saturating increment (11 stays 11); target <= PCTargetE.
  - Hit with TakenE=0: counter saturating decrement (00 stays 00); target unchanged.
- BranchE=0: no state change.
- Same-cycle lookup and update to the same index: the lookup returns pre-update state. There is no write-to-read bypass, and the new state is visible the following cycle.
- PCF[1:0] and PCE[1:0] are ignored.
- Reset (reset=0 at a rising edge) has priority over update.
  - All valid bits clear to 0 and all counters to 01. Tags and targets need not be cleared.
  - Outputs are therefore HitF=0, PredTakenF=0, PredPCTargetF=0 from the cycle after reset is sampled.
  - A reset asserted mid-training discards all learned state, and the update presented in that cycle is dropped.
- Aliasing: two PCs with the same index and different tags evict each other. Exactly one entry is written per update.
- No stall input. Stalls are handled by the fetch stage holding PCF, which keeps the lookup stable.

Test Plan:
- Reset then lookup: hold reset=0 one cycle, release, PCF=0x0000_0040 -> HitF=0, PredTakenF=0, PredPCTargetF=0.
- Allocate taken: BranchE=1, TakenE=1, PCE=0x0000_0040, PCTargetE=0x0000_0100 for one edge; next cycle PCF=0x40 -> HitF=1, PredTakenF=1 (counter 10), PredPCTargetF=0x100.
- Saturation/hysteresis:
  - From 10: two taken updates -> 11.
  - Then one not-taken -> 10, PredTakenF still 1.
  - Then second not-taken -> 01, PredTakenF=0.
  - Then three more not-taken -> counter holds 00.
  - PredPCTargetF stays 0x100 throughout.
- Alias eviction: after the entry above, update PCE=0x0000_0440 (same index 0, different tag), TakenE=0 -> PCF=0x40 gives HitF=0; PCF=0x440 gives HitF=1, PredTakenF=0 (counter 01).
- Same-cycle read/write: PCF=PCE=0x80 on an empty entry with BranchE=1, TakenE=1 -> HitF=0 that cycle, HitF=1 and PredTakenF=1 the next cycle.
- Reset priority: train entry at 0x40 to 11, then assert reset=0 in the same cycle as BranchE=1 for PCE=0x80 -> afterwards both 0x40 and 0x80 miss.
